// File: rtl/m_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pkg_dmem
// Brief   : Shared widths and arbiter state encoding for the data memory.
// Revision: 1.0 - initial release
// ============================================================================
package pkg_dmem;

    localparam int c_ADDR_W  = 12;
    localparam int c_DATA_W  = 32;
    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FORCE = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_RESP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/m_dmem_arbiter_sp_ram.sv
`default_nettype none
// ============================================================================
// Module  : m_sp_ram
// Brief   : Single-port synchronous RAM, write-first, registered output.
// Revision: 1.0 - initial release
// ============================================================================
module m_sp_ram
    import pkg_dmem::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_dout;

    // No reset: contents and output register are left to the array primitive.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
            r_dout        <= i_din;
        end else begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/m_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : m_dmem_arbiter
// Brief   : Shares the MEM-stage data RAM between the pipeline and a host port,
//           forcing one pipeline stall when a host request has waited too long.
// Revision: 1.0 - initial release
// ============================================================================
module m_dmem_arbiter
    import pkg_dmem::*;
#(
    parameter int ADDR_W       = c_ADDR_W,
    parameter int DATA_W       = c_DATA_W,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              p_re,
    input  logic              p_we,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              w_stall,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]     r_starve_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic              w_p_en;
    logic              w_host_grant;
    logic              w_at_limit;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_din;
    logic [DATA_W-1:0] w_ram_dout;

    logic              r_p_rd_q;
    logic [DATA_W-1:0] r_hold_q;
    logic              r_h_rd_q;
    logic [DATA_W-1:0] r_h_rdata_q;

    assign w_p_en     = p_re | p_we;
    assign w_at_limit = (r_starve_cnt == c_CNT_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_starve_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (h_req) begin
                    if (!w_p_en) begin
                        w_state_nxt = c_ST_RESP;
                    end else if (w_at_limit) begin
                        // Only reachable with STARVE_LIMIT=1: one pipeline cycle is the whole budget.
                        w_state_nxt = c_ST_FORCE;
                    end else begin
                        w_cnt_nxt   = r_starve_cnt + CNT_W'(1);
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (!w_p_en) begin
                    w_state_nxt = c_ST_RESP;
                end else if (w_at_limit) begin
                    w_state_nxt = c_ST_FORCE;
                end else begin
                    w_cnt_nxt = r_starve_cnt + CNT_W'(1);
                end
            end
            c_ST_FORCE: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_stall      = (r_state == c_ST_FORCE);
        h_ack        = (r_state == c_ST_RESP);
        w_host_grant = (r_state == c_ST_FORCE) ||
                       (!w_p_en && ((r_state == c_ST_IDLE && h_req) || r_state == c_ST_WAIT));
    end

    // ---------------------------------------------------------------- RAM port mux
    assign w_ram_addr = w_host_grant ? h_addr  : p_addr;
    assign w_ram_din  = w_host_grant ? h_wdata : p_wdata;
    assign w_ram_we   = !w_rst && (w_host_grant ? h_we : p_we);

    m_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (w_clk),
        .i_addr (w_ram_addr),
        .i_we   (w_ram_we),
        .i_din  (w_ram_din),
        .o_dout (w_ram_dout)
    );

    // ---------------------------------------------------------------- read-data tracking
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_starve_cnt <= '0;
            r_p_rd_q     <= 1'b0;
            r_hold_q     <= '0;
            r_h_rd_q     <= 1'b0;
            r_h_rdata_q  <= '0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            r_p_rd_q     <= p_re && !w_host_grant;
            r_h_rd_q     <= w_host_grant && !h_we;
            // Keep the last pipeline load so a frozen WB stage sees a stable value.
            if (r_p_rd_q) begin
                r_hold_q <= w_ram_dout;
            end
            if (r_state == c_ST_RESP && r_h_rd_q) begin
                r_h_rdata_q <= w_ram_dout;
            end
        end
    end

    assign p_rdata = r_p_rd_q ? w_ram_dout : r_hold_q;
    assign h_rdata = (r_state == c_ST_RESP && r_h_rd_q) ? w_ram_dout : r_h_rdata_q;

`ifndef SYNTHESIS
    // Host must hold its request and its command steady until it is served.
    a_host_stable: assert property (@(posedge w_clk) disable iff (w_rst)
        (r_state == c_ST_WAIT || r_state == c_ST_FORCE) |->
            (h_req && h_we == $past(h_we) && h_addr == $past(h_addr)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_dmem_arbiter
// Brief   : Directed self-checking bench for m_dmem_arbiter (STARVE_LIMIT=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_m_dmem_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;
    localparam int CNT_W        = 8;

    logic              w_clk;
    logic              w_rst;
    logic [ADDR_W-1:0] p_addr;
    logic              p_re;
    logic              p_we;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              w_stall;
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;

    int n_checks = 0;
    int n_errors = 0;

    m_dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .p_addr  (p_addr),
        .p_re    (p_re),
        .p_we    (p_we),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .w_stall (w_stall),
        .h_req   (h_req),
        .h_we    (h_we),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_ack   (h_ack),
        .h_rdata (h_rdata)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    // Raise a host request and wait for its ack; lat counts clock edges from request to ack.
    task automatic host_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           output logic [DATA_W-1:0] rdata, output int lat);
        h_req   = 1'b1;
        h_we    = we;
        h_addr  = addr;
        h_wdata = wdata;
        lat     = 0;
        while (h_ack !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (h_ack !== 1'b1) check("host_timeout", 32'(h_ack), 32'd1);
        rdata = h_rdata;
        h_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] rd;
        int                lat;
        int                n_stall;
        int                stall_edge;
        int                ack_edge;
        int                last_ack;
        int                idx;
        logic [ADDR_W-1:0] t6_addr [3];
        logic [DATA_W-1:0] t6_data [3];

        w_rst = 1'b1;
        p_addr = '0; p_re = 1'b0; p_we = 1'b0; p_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        step();
        step();
        check("rst_h_ack",   32'(h_ack),   32'd0);
        check("rst_w_stall", 32'(w_stall), 32'd0);
        check("rst_h_rdata", h_rdata,      32'h0);
        check("rst_p_rdata", p_rdata,      32'h0);
        w_rst = 1'b0;
        step();

        // 1: unloaded host write, then read it back through the pipeline port
        host_op(1'b1, 12'h100, 32'hDEADBEEF, rd, lat);
        check("t1_latency", 32'(lat),     32'd1);
        check("t1_w_stall", 32'(w_stall), 32'd0);
        p_re = 1'b1; p_addr = 12'h100;
        step();
        check("t1_ram", p_rdata, 32'hDEADBEEF);
        p_re = 1'b0;

        // preload words used later
        p_we = 1'b1;
        p_addr = 12'h040; p_wdata = 32'h5;        step();
        p_addr = 12'h020; p_wdata = 32'h0;        step();
        p_addr = 12'h300; p_wdata = 32'h11111111; step();
        p_we = 1'b0;

        // 2+3: host read under continuous pipeline loads of 0x040
        p_re = 1'b1; p_addr = 12'h040;
        h_req = 1'b1; h_we = 1'b0; h_addr = 12'h100; h_wdata = '0;
        n_stall = 0; stall_edge = 0; ack_edge = 0;
        for (int e = 1; e <= 20 && ack_edge == 0; e++) begin
            step();
            if (w_stall === 1'b1) begin
                n_stall++;
                stall_edge = e;
                check("t3_p_rdata_force", p_rdata, 32'h5);
            end
            if (h_ack === 1'b1) begin
                ack_edge = e;
                check("t3_p_rdata_resp", p_rdata, 32'h5);
                check("t2_h_rdata",      h_rdata, 32'hDEADBEEF);
                h_req = 1'b0;
            end
        end
        check("t2_stall_count", 32'(n_stall),    32'd1);
        check("t2_stall_edge",  32'(stall_edge), 32'(STARVE_LIMIT));
        check("t2_ack_edge",    32'(ack_edge),   32'(STARVE_LIMIT + 1));
        step();
        check("t3_replay_load", p_rdata, 32'h5);
        p_re = 1'b0;

        // 4: forced host write collides with a replayed pipeline store
        p_we = 1'b1; p_addr = 12'h020; p_wdata = 32'h2;
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h020; h_wdata = 32'h1;
        ack_edge = 0;
        for (int e = 1; e <= 20 && ack_edge == 0; e++) begin
            step();
            if (h_ack === 1'b1) begin
                ack_edge = e;
                h_req = 1'b0;
            end
        end
        check("t4_ack_edge", 32'(ack_edge), 32'(STARVE_LIMIT + 1));
        step();
        p_we = 1'b0;
        host_op(1'b0, 12'h020, '0, rd, lat);
        check("t4_final", rd, 32'h2);
        step();

        // 5: reset while the host write is waiting
        p_re = 1'b1; p_addr = 12'h040;
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h300; h_wdata = 32'hCAFEF00D;
        step();
        step();
        check("t5_wait_ack", 32'(h_ack), 32'd0);
        w_rst = 1'b1; h_req = 1'b0; p_re = 1'b0;
        #1;
        check("t5_rst_ack",     32'(h_ack),   32'd0);
        check("t5_rst_stall",   32'(w_stall), 32'd0);
        check("t5_rst_p_rdata", p_rdata,      32'h0);
        check("t5_rst_h_rdata", h_rdata,      32'h0);
        step();
        step();
        w_rst = 1'b0;
        step();
        check("t5_no_ack", 32'(h_ack), 32'd0);
        host_op(1'b0, 12'h300, '0, rd, lat);
        check("t5_latency",   32'(lat), 32'd1);
        check("t5_not_lande", rd,       32'h11111111);
        step();

        // 6: back-to-back host reads with an idle pipeline
        t6_addr[0] = 12'h100; t6_data[0] = 32'hDEADBEEF;
        t6_addr[1] = 12'h020; t6_data[1] = 32'h2;
        t6_addr[2] = 12'h040; t6_data[2] = 32'h5;
        idx = 0; last_ack = 0;
        h_req = 1'b1; h_we = 1'b0; h_addr = t6_addr[0];
        for (int e = 1; e <= 12 && idx < 3; e++) begin
            step();
            if (h_ack === 1'b1) begin
                check("t6_data",     h_rdata,           t6_data[idx]);
                check("t6_interval", 32'(e - last_ack), (idx == 0) ? 32'd1 : 32'd2);
                last_ack = e;
                idx++;
                if (idx < 3) h_addr = t6_addr[idx];
                else h_req = 1'b0;
            end
        end
        check("t6_count", 32'(idx), 32'd3);
        step();
        check("t6_ack_pulse", 32'(h_ack), 32'd0);
        check("t6_hold",      h_rdata,    32'h5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
